// File: rtl/mul_seq_ctrl_pkg.sv
// Shared constants for the iterative EX-stage multiplier: word width, FSM
// state encodings and a counter-width helper.
package mul_seq_ctrl_pkg;

    localparam int MUL_WORD = 32;

    typedef logic [1:0] mul_state_t;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_RUN  = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    // A single-step configuration still needs a one-bit counter.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: adds mcand times the low BPC multiplier bits to the
// accumulator, truncated to WORD bits.
module mul_step #(
    parameter int WORD = 32,
    parameter int BPC  = 2
) (
    input  logic [WORD-1:0] acc,
    input  logic [WORD-1:0] mcand,
    input  logic [BPC-1:0]  mplier_bits,
    output logic [WORD-1:0] acc_next
);

    logic [WORD-1:0] pp [BPC];

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
            assign pp[gi] = mplier_bits[gi] ? (mcand << gi) : '0;
        end
    endgenerate

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BPC; i++) begin
            acc_next = acc_next + pp[i];
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative low-word multiplier with operand/result valid-ready handshakes,
// optional early exit on an exhausted multiplier, and flush support.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WORD      = MUL_WORD,
    parameter int BPC       = 2,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] src0,
    input  logic [WORD-1:0] src1,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    localparam int STEPS = WORD / BPC;
    localparam int CNT_W = cnt_width(STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    mul_state_t      state_reg,     state_next;
    logic [WORD-1:0] mcand_reg,     mcand_next;
    logic [WORD-1:0] mplier_reg,    mplier_next;
    logic [WORD-1:0] acc_reg,       acc_next;
    logic [CNT_W-1:0] cnt_reg,      cnt_next;
    logic [4:0]      tag_reg,       tag_next;
    logic [WORD-1:0] result_reg,    result_next;
    logic [4:0]      rd_out_reg,    rd_out_next;
    logic            out_valid_reg, out_valid_next;

    logic [WORD-1:0] acc_step;
    logic [WORD-1:0] mplier_post;
    logic            accept;
    logic            run_exit;

    mul_step #(
        .WORD (WORD),
        .BPC  (BPC)
    ) u_step (
        .acc         (acc_reg),
        .mcand       (mcand_reg),
        .mplier_bits (mplier_reg[BPC-1:0]),
        .acc_next    (acc_step)
    );

    assign in_ready    = (state_reg == MUL_IDLE);
    assign busy        = (state_reg != MUL_IDLE);
    assign accept      = in_valid & in_ready & ~flush;
    assign mplier_post = mplier_reg >> BPC;
    assign run_exit    = (cnt_reg == CNT_LAST) || (EARLY_OUT && (mplier_post == '0));

    always_comb begin
        state_next     = state_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        tag_next       = tag_reg;
        result_next    = result_reg;
        rd_out_next    = rd_out_reg;
        out_valid_next = out_valid_reg;

        case (state_reg)
            MUL_IDLE: begin
                if (accept) begin
                    mcand_next  = src0;
                    mplier_next = src1;
                    tag_next    = rd_in;
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = MUL_RUN;
                end
            end
            MUL_RUN: begin
                acc_next    = acc_step;
                mcand_next  = mcand_reg << BPC;
                mplier_next = mplier_post;
                cnt_next    = cnt_reg + 1'b1;
                if (run_exit) begin
                    state_next     = MUL_DONE;
                    result_next    = acc_step;
                    rd_out_next    = tag_reg;
                    out_valid_next = 1'b1;
                end
            end
            MUL_DONE: begin
                if (out_ready) begin
                    state_next     = MUL_IDLE;
                    out_valid_next = 1'b0;
                end
            end
            default: begin
                state_next     = MUL_IDLE;
                out_valid_next = 1'b0;
            end
        endcase

        // A redirect kills whatever is in flight, including an unclaimed result.
        if (flush) begin
            state_next     = MUL_IDLE;
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= MUL_IDLE;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            tag_reg       <= '0;
            result_reg    <= '0;
            rd_out_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mcand_reg     <= mcand_next;
            mplier_reg    <= mplier_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            tag_reg       <= tag_next;
            result_reg    <= result_next;
            rd_out_reg    <= rd_out_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign rd_out    = rd_out_reg;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: one instance without and one with early exit,
// table-driven vectors plus hand-written handshake/flush/reset sequences.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] src0, src1;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_ready;
    logic        sel;

    logic        in_ready0, out_valid0, busy0;
    logic [31:0] result0;
    logic [4:0]  rd_out0;
    logic        in_ready1, out_valid1, busy1;
    logic [31:0] result1;
    logic [4:0]  rd_out1;

    logic        in_valid0, in_valid1;
    logic        in_ready_s, out_valid_s, busy_s;
    logic [31:0] result_s;
    logic [4:0]  rd_out_s;

    always #5 clk = ~clk;

    assign in_valid0   = in_valid & ~sel;
    assign in_valid1   = in_valid & sel;
    assign in_ready_s  = sel ? in_ready1  : in_ready0;
    assign out_valid_s = sel ? out_valid1 : out_valid0;
    assign busy_s      = sel ? busy1      : busy0;
    assign result_s    = sel ? result1    : result0;
    assign rd_out_s    = sel ? rd_out1    : rd_out0;

    mul_seq_ctrl #(.WORD(32), .BPC(2), .EARLY_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .src0(src0), .src1(src1), .rd_in(rd_in), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
        .rd_out(rd_out0), .busy(busy0)
    );

    mul_seq_ctrl #(.WORD(32), .BPC(2), .EARLY_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .src0(src0), .src1(src1), .rd_in(rd_in), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
        .rd_out(rd_out1), .busy(busy1)
    );

    typedef struct {
        logic        early;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t scoreboard[$];
    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Cycles from accept edge to out_valid: independent bit-length model.
    function automatic int model_lat(input logic early, input logic [31:0] b);
        int bl = 0;
        int steps;
        if (!early) return 17;
        for (int i = 0; i < 32; i++) if (b[i]) bl = i + 1;
        steps = (bl + 1) / 2;
        if (steps < 1) steps = 1;
        return steps + 1;
    endfunction

    // Accept one op, wait for out_valid, optionally hold the result while
    // poking in_valid, then complete the output handshake.
    task automatic do_op(input logic early, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res,
                         input int exp_lat, input int hold);
        exp_t e;
        int   cyc;
        @(negedge clk);
        sel = early;
        check("in_ready_before", {31'b0, in_ready_s}, 32'd1);
        src0 = a; src1 = b; rd_in = rd; in_valid = 1'b1; out_ready = 1'b0;
        scoreboard.push_back('{res: exp_res, rd: rd, lat: exp_lat});
        @(negedge clk);
        in_valid = 1'b0;
        src0 = 32'hA5A5_A5A5; src1 = 32'h5A5A_5A5A; rd_in = 5'd0;
        cyc = 1;
        check("busy_cycle1", {31'b0, busy_s}, 32'd1);
        while (!out_valid_s && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        e = scoreboard.pop_front();
        if (!out_valid_s) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            return;
        end
        check("latency", cyc, e.lat);
        check("result", result_s, e.res);
        check("rd_out", {27'b0, rd_out_s}, {27'b0, e.rd});
        for (int h = 0; h < hold; h++) begin
            src0 = 32'd9; src1 = 32'd9; rd_in = 5'd31;
            in_valid = (h == 2);
            @(negedge clk);
            check("hold_out_valid", {31'b0, out_valid_s}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready_s}, 32'd0);
            check("hold_result", result_s, e.res);
            check("hold_rd_out", {27'b0, rd_out_s}, {27'b0, e.rd});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", {31'b0, out_valid_s}, 32'd0);
        check("post_in_ready", {31'b0, in_ready_s}, 32'd1);
        $display("op early=%0d 0x%08h*0x%08h rd=%0d -> 0x%08h after %0d cycles",
                 early, a, b, rd, result_s, cyc);
    endtask

    initial begin
        int cyc;
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; src0 = '0; src1 = '0; rd_in = '0;
        flush = 1'b0; out_ready = 1'b0; sel = 1'b0;

        vecs[0] = '{1'b0, 32'd7,          32'd6,          5'd5,  32'd42,         17};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0001,  17};
        vecs[2] = '{1'b0, 32'h8000_0000,  32'd2,          5'd2,  32'h0000_0000,  17};
        vecs[3] = '{1'b1, 32'h1234_5678,  32'd0,          5'd3,  32'h0000_0000,  2};
        vecs[4] = '{1'b1, 32'd5,          32'd3,          5'd4,  32'd15,         2};
        vecs[5] = '{1'b1, 32'd1,          32'h8000_0000,  5'd6,  32'h8000_0000,  17};
        vecs[6] = '{1'b1, 32'h1234_5678,  32'h10,         5'd7,  32'h2345_6780,  4};
        vecs[7] = '{1'b1, 32'hFFFF_FFFF,  32'd7,          5'd8,  32'hFFFF_FFF9,  3};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #0;
            check("reset_in_ready", {31'b0, in_ready_s}, 32'd1);
            check("reset_busy", {31'b0, busy_s}, 32'd0);
            check("reset_out_valid", {31'b0, out_valid_s}, 32'd0);
            check("reset_result", result_s, 32'd0);
            check("reset_rd_out", {27'b0, rd_out_s}, 32'd0);
        end

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].early, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp_res, vecs[i].exp_lat, 0);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
            do_op(i[0], ra, rb, 5'($urandom_range(0, 31)), ra * rb, model_lat(i[0], rb), 0);
        end

        // Result held in DONE while in_valid pulses
        do_op(1'b0, 32'd11, 32'd13, 5'd9, 32'd143, 17, 5);

        // Flush during RUN cycle 5, then next op on the following cycle
        @(negedge clk);
        sel = 1'b0;
        src0 = 32'd7; src1 = 32'd6; rd_in = 5'd10; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy_s}, 32'd0);
        check("flush_out_valid", {31'b0, out_valid_s}, 32'd0);
        do_op(1'b0, 32'd3, 32'd4, 5'd11, 32'd12, 17, 0);

        // in_valid together with flush in IDLE is not accepted
        @(negedge clk);
        sel = 1'b1; src0 = 32'd2; src1 = 32'd2; rd_in = 5'd12;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", {31'b0, busy_s}, 32'd0);

        // Flush while a result waits in DONE drops it
        @(negedge clk);
        sel = 1'b1; src0 = 32'd5; src1 = 32'd3; rd_in = 5'd13; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("done_before_flush", {31'b0, out_valid_s}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_out_valid", {31'b0, out_valid_s}, 32'd0);
        check("flush_done_in_ready", {31'b0, in_ready_s}, 32'd1);

        // Reset while DONE with out_valid high
        @(negedge clk);
        sel = 1'b1; src0 = 32'd5; src1 = 32'd3; rd_in = 5'd14; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_out_valid", {31'b0, out_valid_s}, 32'd1);
        check("rst_pre_result", result_s, 32'd15);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", {31'b0, out_valid_s}, 32'd0);
        check("rst_result", result_s, 32'd0);
        check("rst_rd_out", {27'b0, rd_out_s}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready_s}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
